uart_rx_8n1: RTL and testbench
==============================

Name: uart_rx_8n1

Overview:
- UART 8N1 receive-only block; the receive counterpart of the team's 8N1 transmitter.
- Recovers bytes from the serial line, LSB first.
- Delivers each byte on a valid/ready handshake to the downstream consumer, e.g. a loader writing input/weight SRAM from a host.
- Synchronizes the asynchronous line, samples each bit at mid-bit, and flags framing and overrun errors.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit. Must be even and >= 4.
- SYNC_STAGES, 2: flops in the rx input synchronizer. Must be >= 2.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: reset, asynchronous, active-high; clock clk.
- rx, input, 1: serial line. Idles high. Asynchronous to clk.
- rx_data, output, 8: received byte. Stable while rx_valid=1.
- rx_valid, output, 1: rx_data holds an unconsumed byte.
- rx_ready, input, 1: consumer accepts the byte in this cycle.
- frame_err, output, 1: one-cycle pulse when the stop bit is sampled low.
- overrun_err, output, 1: one-cycle pulse when a new byte arrives while the previous byte is unconsumed.
- busy, output, 1: high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync release):
  - Synchronizer flops = 1, state = IDLE, counters = 0.
  - rx_data = 0x00; rx_valid, frame_err, overrun_err, busy = 0.
- Synchronizer: rx passes through SYNC_STAGES flops; the last stage is rx_s. All FSM decisions use rx_s only.
- Counters:
  - cnt counts 0..CLKS_PER_BIT-1.
  - bit_idx counts 0..7.
  - A counter reaching its terminal value resets to 0 in the same edge as the sample.
- FSM states: IDLE, START, DATA, STOP, RECOVER.
  - IDLE: rx_s=0 -> START, cnt=0.
  - START:
    - cnt increments each cycle.
    - At cnt=CLKS_PER_BIT/2-1, sample rx_s.
    - Sample 0 -> DATA, cnt=0, bit_idx=0.
    - Sample 1 -> IDLE. This is glitch rejection: no error, no output.
  - DATA:
    - At cnt=CLKS_PER_BIT-1, shift rx_s into bit 7 of shift register (shift right) and increment bit_idx.
    - After the sample at bit_idx=7 -> STOP.
  - STOP: at cnt=CLKS_PER_BIT-1, sample rx_s.
    - 1 -> deliver the byte, go to IDLE.
    - 0 -> frame_err=1 for exactly one cycle, byte discarded, go to RECOVER.
  - RECOVER: stay until rx_s=1, then -> IDLE. A held-low break line therefore produces exactly one frame_err.
- Timing: all samples land at mid-bit. The stop bit is sampled half a bit before its end, so back-to-back frames with one stop bit are received.
- Delivery (at the edge after the stop sample):
  - rx_valid=0, or (rx_valid=1 and rx_ready=1): load rx_data, set rx_valid=1.
  - rx_valid=1 and rx_ready=0: overrun_err=1 for one cycle. New byte dropped; rx_data and rx_valid unchanged.
- Handshake:
  - rx_valid=1 and rx_ready=1 with no delivery in that cycle: clear rx_valid next edge; rx_data keeps its last value.
  - rx_ready while rx_valid=0 has no effect.
  - Delivery and consumption are never simultaneous on the same byte.
- Latency: from the first clk edge at which rx is low, rx_valid rises SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles later (+/-1 cycle due to async rx).
- Error pulses:
  - frame_err and overrun_err are never asserted in the same cycle.
  - Neither is asserted on the glitch-reject path.
- Reset mid-frame: immediate return to reset values, including clearing a pending rx_valid. The first full frame after release is received correctly.

Test Plan:
- Send 0xA5 (CLKS_PER_BIT=16), rx_ready=1 -> rx_valid rises once with rx_data=0xA5 within the latency window; frame_err=0, overrun_err=0; busy falls after the stop sample.
- Drive rx low for 4 cycles, then high -> no rx_valid, no frame_err; busy high for about 8 cycles, then 0.
- Send 0x3C with stop bit 0, hold rx low 3 bit times, release, then send 0x55 -> exactly one frame_err pulse, no rx_valid for 0x3C; then rx_data=0x55, rx_valid=1.
- rx_ready=0; send 0x11 then 0x22 back-to-back -> rx_data=0x11 held, overrun_err pulses once at the 0x22 stop sample; raise rx_ready -> rx_valid drops next cycle.
- Send 0x00, 0xFF, 0x81 back-to-back with one stop bit each, rx_ready=1 -> three deliveries in order, no errors.
- Assert reset during data bit 4 of 0x96 with rx_valid=1 pending -> all outputs 0 immediately; after release, send 0xC3 -> rx_data=0xC3, no errors.

Source files
------------

// File: rtl/uart_rx_8n1.sv
// rtl/uart_rx_8n1.sv - UART 8N1 receiver with mid-bit sampling and valid/ready delivery
// Framing and overrun errors are reported as single-cycle pulses.
module uart_rx_8n1 #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_STOP    = 3'd3;
  localparam logic [2:0] ST_RECOVER = 3'd4;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [2:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_err_q, overrun_err_d;
  logic                   deliver_q, deliver_d;
  logic                   rx_s;

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d        = {sync_q[SYNC_STAGES-2:0], rx};
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    frame_err_d   = 1'b0;
    overrun_err_d = 1'b0;
    deliver_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          // A start bit that is high again at mid-bit is treated as a glitch.
          state_d   = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
            state_d   = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            deliver_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_RECOVER;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RECOVER: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Delivery happens one edge after the stop sample; shift_q is stable then.
    if (deliver_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_err_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q        <= '1;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= 3'd0;
      shift_q       <= 8'h00;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      deliver_q     <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
      deliver_q     <= deliver_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb/tb_uart_rx_8n1.sv - self-checking bench for uart_rx_8n1
// Frames are generated bit by bit; accepted bytes are matched against a queue of sent bytes.
module tb_uart_rx_8n1;

  localparam int C   = 16;
  localparam int SS  = 2;
  localparam int LAT = SS + C / 2 + 9 * C + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;

  uart_rx_8n1 #(.CLKS_PER_BIT(C), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun_err(overrun_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int fe_cnt = 0;
  int ov_cnt = 0;
  int rise_cnt = 0;
  int t_rise = 0;
  int busy_cnt = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) check("unexpected_byte", {24'h0, rx_data}, 32'hFFFF_FFFF);
        else check("rx_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
      end
      if (rx_valid && !prev_valid) begin
        rise_cnt++;
        t_rise = cyc;
      end
      prev_valid = rx_valid;
      if (frame_err) fe_cnt++;
      if (overrun_err) ov_cnt++;
      if (busy) busy_cnt++;
      if (frame_err && overrun_err) check("err_exclusive", 1, 0);
    end
  end

  task automatic send_bit(input logic v);
    rx = v;
    repeat (C) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int fe0, ov0, r0, t0, lat;
  logic [7:0] rb;

  initial begin
    reset = 1'b1;
    rx = 1'b1;
    rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_errs", {frame_err, overrun_err}, 0);
    reset = 1'b0;
    idle(5);

    // single byte with latency
    r0 = rise_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
    t0 = cyc;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    idle(4);
    lat = t_rise - (t0 + 1);
    check("latency_in_window", (lat >= LAT - 1 && lat <= LAT + 1), 1);
    check("a5_rises", rise_cnt - r0, 1);
    check("a5_fe", fe_cnt - fe0, 0);
    check("a5_ov", ov_cnt - ov0, 0);
    check("a5_busy_low", busy, 0);

    // glitch rejection
    idle(10);
    r0 = rise_cnt; fe0 = fe_cnt; busy_cnt = 0;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(40);
    check("glitch_rises", rise_cnt - r0, 0);
    check("glitch_fe", fe_cnt - fe0, 0);
    check("glitch_busy_cycles", (busy_cnt >= C / 2 - 1 && busy_cnt <= C / 2 + 1), 1);
    check("glitch_busy_end", busy, 0);

    // framing error with held break, then a good byte
    fe0 = fe_cnt; r0 = rise_cnt;
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    repeat (2 * C) @(posedge clk);
    #1;
    idle(2 * C);
    check("break_fe_once", fe_cnt - fe0, 1);
    check("break_no_valid", rise_cnt - r0, 0);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    idle(4);
    check("after_break_rises", rise_cnt - r0, 1);

    // overrun with consumer stalled
    idle(C);
    rx_ready = 1'b0;
    ov0 = ov_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(4);
    check("ovr_pulse_once", ov_cnt - ov0, 1);
    check("ovr_data_held", rx_data, 8'h11);
    check("ovr_valid_held", rx_valid, 1);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    check("ovr_valid_drop", rx_valid, 0);
    check("ovr_data_keep", rx_data, 8'h11);

    // back-to-back frames
    fe0 = fe_cnt; ov0 = ov_cnt; r0 = rise_cnt;
    exp_q.push_back(8'h00); send_frame(8'h00, 1'b1);
    exp_q.push_back(8'hFF); send_frame(8'hFF, 1'b1);
    exp_q.push_back(8'h81); send_frame(8'h81, 1'b1);
    idle(4);
    check("b2b_rises", rise_cnt - r0, 3);
    check("b2b_errs", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

    // randomized bytes with random idle gaps
    fe0 = fe_cnt; ov0 = ov_cnt;
    for (int k = 0; k < 16; k++) begin
      rb = 8'($urandom_range(0, 255));
      exp_q.push_back(rb);
      send_frame(rb, 1'b1);
      idle($urandom_range(0, 2 * C));
    end
    idle(4);
    check("rand_errs", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    check("rand_queue_drained", exp_q.size(), 0);

    // reset mid-frame with a pending byte
    rx_ready = 1'b0;
    send_frame(8'h5A, 1'b1);
    idle(4);
    check("pend_valid", rx_valid, 1);
    check("pend_data", rx_data, 8'h5A);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0 ^ (8'h96 >> i) & 1'b1);
    rx = (8'h96 >> 4) & 1'b1;
    repeat (C / 2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_valid", rx_valid, 0);
    check("midrst_data", rx_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_errs", {frame_err, overrun_err}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rx_ready = 1'b1;
    idle(2 * C);
    fe0 = fe_cnt; ov0 = ov_cnt;
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    idle(4);
    check("post_rst_errs", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    check("final_queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
